// File: rtl/fb_port_a_ctrl.sv
// fb_port_a_ctrl: port-A arbiter/sequencer sharing the framebuffer BSRAM between the CPU and the fill engine (fill engine compiled in with FB_FILL_EN)
module fb_port_a_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int CPU_BURST_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_rvalid,
  input  logic              i_fill_start,
  input  logic [ADDR_W-1:0] i_fill_base,
  input  logic [ADDR_W:0]   i_fill_len,
  input  logic [DATA_W-1:0] i_fill_value,
  output logic              o_fill_busy,
  output logic              o_fill_done,
  output logic [ADDR_W-1:0] o_ram_ada,
  output logic [DATA_W-1:0] o_ram_dina,
  output logic              o_ram_wrea,
  output logic              o_ram_cea,
  output logic              o_ram_ocea,
  input  logic [DATA_W-1:0] i_ram_douta
);
  typedef enum logic [1:0] {IDLE, CPU, FILL} state_t;
  state_t r_state, w_state;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic w_gwe;
  logic [1:0] r_tag;
  assign o_ram_ocea = 1'b1;
  assign o_cpu_ack = r_state == CPU;
`ifdef FB_FILL_EN
  localparam int BW = $clog2(CPU_BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(CPU_BURST_MAX);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  logic [ADDR_W:0] r_rem, w_rem, w_len, w_src_cnt;
  logic [ADDR_W-1:0] r_faddr, w_faddr, w_src_addr;
  logic [DATA_W-1:0] r_fval, w_fval;
  logic [BW-1:0] r_burst, w_burst;
  logic w_pend, w_start, w_cpu, w_fgo, w_busy, w_done;
  // Pick the next port-A slot owner and advance the fill sequencer and burst limiter
  always_comb begin
    w_pend = r_rem != '0;
    w_start = i_fill_start && !o_fill_busy;
    w_len = i_fill_len > DEPTH ? DEPTH : i_fill_len;
    w_cpu = i_cpu_req && (!w_pend || r_burst < BMAX);
    w_fgo = !w_cpu && (w_pend || (w_start && w_len != '0));
    w_src_addr = w_pend ? r_faddr : i_fill_base;
    w_src_cnt = w_pend ? r_rem : w_len;
    w_faddr = w_fgo ? w_src_addr + 1'b1 : w_start ? i_fill_base : r_faddr;
    w_rem = w_fgo ? w_src_cnt - 1'b1 : w_start ? w_len : r_rem;
    w_fval = w_start ? i_fill_value : r_fval;
    w_burst = (w_fgo || !w_pend) ? '0 : (w_cpu && r_burst != BMAX) ? r_burst + 1'b1 : r_burst;
    w_busy = w_rem != '0 || w_fgo;
    w_done = (o_fill_busy && !w_busy) || (w_start && w_len == '0);
    w_state = w_cpu ? CPU : w_fgo ? FILL : IDLE;
    w_gaddr = w_cpu ? i_cpu_addr : w_src_addr;
    w_gdata = w_cpu ? i_cpu_wdata : w_fval;
    w_gwe = w_cpu ? i_cpu_we : 1'b1;
  end
  // Fill engine registers: remaining bytes, next address, fill byte, CPU burst count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rem <= '0;
      r_faddr <= '0;
      r_fval <= '0;
      r_burst <= '0;
      o_fill_busy <= 1'b0;
      o_fill_done <= 1'b0;
    end else begin
      r_rem <= w_rem;
      r_faddr <= w_faddr;
      r_fval <= w_fval;
      r_burst <= w_burst;
      o_fill_busy <= w_busy;
      o_fill_done <= w_done;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_fill_start, i_fill_base, i_fill_len, i_fill_value, CPU_BURST_MAX[0]};
  assign o_fill_busy = 1'b0;
  assign o_fill_done = 1'b0;
  // Without the fill engine the CPU owns every slot it asks for
  always_comb begin
    w_state = i_cpu_req ? CPU : IDLE;
    w_gaddr = i_cpu_addr;
    w_gdata = i_cpu_wdata;
    w_gwe = i_cpu_we;
  end
`endif
  // Slot owner, registered RAM pins, read-tag pipe and CPU read-data capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      o_ram_ada <= '0;
      o_ram_dina <= '0;
      o_ram_wrea <= 1'b0;
      o_ram_cea <= 1'b0;
      r_tag <= '0;
      o_cpu_rdata <= '0;
      o_cpu_rvalid <= 1'b0;
    end else begin
      r_state <= w_state;
      o_ram_cea <= w_state != IDLE;
      o_ram_wrea <= w_state != IDLE && w_gwe;
      if (w_state != IDLE) begin
        o_ram_ada <= w_gaddr;
        o_ram_dina <= w_gdata;
      end
      r_tag <= {r_tag[0], w_state == CPU && !i_cpu_we};
      o_cpu_rvalid <= r_tag[1];
      if (r_tag[1]) o_cpu_rdata <= i_ram_douta;
    end
  end
endmodule

// File: tb/tb_fb_port_a_ctrl.sv
// tb_fb_port_a_ctrl: directed and randomized checks of fb_port_a_ctrl against a transaction-level model
module tb_fb_port_a_ctrl;
`ifdef FB_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam int MAXB = 4;
  typedef struct {logic we; logic [10:0] addr; logic [7:0] data;} txn_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic cpu_ack, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic fill_start = 1'b0;
  logic [10:0] fill_base = '0;
  logic [11:0] fill_len = '0;
  logic [7:0] fill_value = '0;
  logic fill_busy, fill_done;
  logic [10:0] ram_ada;
  logic [7:0] ram_dina;
  logic ram_wrea, ram_cea, ram_ocea;
  logic [7:0] ram_douta = 8'h00;
  logic [7:0] mem [2048] = '{default: 8'h00};
  logic [7:0] sh [2048] = '{default: 8'h00};
  int rem = 0, faddr = 0, burst = 0, cyc = 0;
  logic [7:0] fval = '0;
  bit busy_e, done_e, ack_e, cea_e, wrea_e, rvalid_e;
  logic [10:0] ada_e = '0;
  logic [7:0] dina_e = '0, rdata_e = '0;
  int rq_due[$];
  logic [7:0] rq_dat[$];
  txn_t cq[$];
  int wq[$];
  int nvec = 0, nerr = 0;
  int nwr = 0, n11 = 0, ndone = 0, nrv = 0, done_cyc = -1, rv_cyc = -1;

  fb_port_a_ctrl dut (
    .i_clk(clk), .i_reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_rvalid(cpu_rvalid),
    .i_fill_start(fill_start), .i_fill_base(fill_base), .i_fill_len(fill_len), .i_fill_value(fill_value),
    .o_fill_busy(fill_busy), .o_fill_done(fill_done),
    .o_ram_ada(ram_ada), .o_ram_dina(ram_dina), .o_ram_wrea(ram_wrea), .o_ram_cea(ram_cea),
    .o_ram_ocea(ram_ocea), .i_ram_douta(ram_douta)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM port A in bypass read mode
  always @(posedge clk) if (ram_cea) begin
    if (ram_wrea) mem[ram_ada] <= ram_dina;
    ram_douta <= ram_wrea ? ram_dina : mem[ram_ada];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic we, logic [10:0] addr, logic [7:0] data);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.data = data;
    cq.push_back(t);
  endtask

  task automatic tick();
    bit pend, cg, so, fg, nb;
    int lc;
    cpu_req = cq.size() > 0;
    if (cq.size() > 0) begin
      cpu_we = cq[0].we;
      cpu_addr = cq[0].addr;
      cpu_wdata = cq[0].data;
    end
    if (reset) begin
      rem = 0; burst = 0; busy_e = 0; done_e = 0; ack_e = 0; cea_e = 0; wrea_e = 0; rvalid_e = 0;
      ada_e = '0; dina_e = '0; rdata_e = '0;
      rq_due.delete(); rq_dat.delete();
    end else begin
      pend = rem > 0;
      cg = cpu_req && (!FILL_EN || !pend || burst < MAXB);
      so = FILL_EN && fill_start && !busy_e;
      lc = int'(fill_len) > 2048 ? 2048 : int'(fill_len);
      if (so) begin faddr = int'(fill_base); rem = lc; fval = fill_value; end
      fg = FILL_EN && !cg && rem > 0;
      burst = (fg || !pend) ? 0 : (cg && burst < MAXB) ? burst + 1 : burst;
      ack_e = cg;
      cea_e = cg || fg;
      wrea_e = cg ? cpu_we : fg;
      if (cg) begin
        ada_e = cpu_addr;
        dina_e = cpu_wdata;
        if (cpu_we) sh[cpu_addr] = cpu_wdata;
        else begin rq_due.push_back(cyc + 3); rq_dat.push_back(sh[cpu_addr]); end
      end else if (fg) begin
        ada_e = 11'(faddr);
        dina_e = fval;
        sh[faddr] = fval;
        faddr = (faddr + 1) % 2048;
        rem--;
      end
      nb = rem > 0 || fg;
      done_e = (busy_e && !nb) || (so && lc == 0);
      busy_e = nb;
      rvalid_e = rq_due.size() > 0 && rq_due[0] == cyc + 1;
      if (rvalid_e) begin void'(rq_due.pop_front()); rdata_e = rq_dat.pop_front(); end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("cpu_ack", cpu_ack, ack_e);
    chk("cpu_rvalid", cpu_rvalid, rvalid_e);
    chk("cpu_rdata", cpu_rdata, rdata_e);
    chk("fill_busy", fill_busy, busy_e);
    chk("fill_done", fill_done, done_e);
    chk("ram_cea", ram_cea, cea_e);
    chk("ram_wrea", ram_wrea, wrea_e);
    chk("ram_ada", ram_ada, ada_e);
    chk("ram_dina", ram_dina, dina_e);
    chk("ram_ocea", ram_ocea, 1'b1);
    if (ram_cea === 1'b1 && ram_wrea === 1'b1) begin
      nwr++;
      wq.push_back(int'(ram_ada));
      if (ram_dina == 8'h11) n11++;
    end
    if (fill_done === 1'b1) begin ndone++; done_cyc = cyc; end
    if (cpu_rvalid === 1'b1) begin nrv++; rv_cyc = cyc; end
    fill_start = 1'b0;
    if (ack_e) void'(cq.pop_front());
  endtask

  task automatic start_fill(logic [10:0] base, logic [11:0] len, logic [7:0] val);
    fill_base = base;
    fill_len = len;
    fill_value = val;
    fill_start = 1'b1;
  endtask

  initial begin
    int s, c_rd;
    txn_t t;
    tick();
    tick();
    reset = 1'b0;
    // CPU write then read-back with latency check
    push(1'b1, 11'h123, 8'h5A);
    push(1'b0, 11'h123, 8'h00);
    c_rd = cyc + 1;
    rv_cyc = -1;
    for (int i = 0; i < 10 && rv_cyc < 0; i++) tick();
    chk("rd_latency", rv_cyc - c_rd, 3);
    chk("rd_data", cpu_rdata, 8'h5A);
    // wrapping fill of 4 bytes
    repeat (3) tick();
    wq.delete(); nwr = 0; ndone = 0; done_cyc = -1;
    s = cyc;
    start_fill(11'h7FE, 12'd4, 8'hFF);
    for (int i = 0; i < 12 && done_cyc < 0; i++) tick();
    repeat (3) tick();
    chk("wrap_nwr", nwr, FILL_EN ? 4 : 0);
    foreach (wq[i]) chk("wrap_addr", wq[i], (32'h7FE + i) % 2048);
    chk("wrap_done_cyc", done_cyc, FILL_EN ? s + 5 : -1);
    chk("wrap_ndone", ndone, FILL_EN ? 1 : 0);
    // continuous CPU reads against a 16-byte fill
    for (int i = 0; i < 100; i++) push(1'b0, 11'($urandom), 8'h00);
    nwr = 0; done_cyc = -1;
    s = cyc;
    start_fill(11'h200, 12'd16, 8'hA5);
    for (int i = 0; i < 200 && done_cyc < 0; i++) tick();
    chk("burst_nwr", nwr, FILL_EN ? 16 : 0);
    chk("burst_done_cyc", done_cyc, FILL_EN ? s + 82 : -1);
    cq.delete();
    repeat (4) tick();
    // zero-length fill
    nwr = 0; done_cyc = -1;
    s = cyc;
    start_fill(11'h050, 12'd0, 8'h99);
    repeat (4) tick();
    chk("len0_nwr", nwr, 0);
    chk("len0_done_cyc", done_cyc, FILL_EN ? s + 1 : -1);
    // oversize length clamps to the whole framebuffer
    nwr = 0; done_cyc = -1;
    start_fill(11'($urandom), 12'hFFF, 8'h3C);
    for (int i = 0; i < 2100 && done_cyc < 0; i++) tick();
    repeat (2) tick();
    chk("clamp_nwr", nwr, FILL_EN ? 2048 : 0);
    // start while busy is ignored
    nwr = 0; n11 = 0; done_cyc = -1;
    start_fill(11'h300, 12'd10, 8'h11);
    repeat (3) tick();
    start_fill(11'h400, 12'd5, 8'h22);
    for (int i = 0; i < 40 && done_cyc < 0; i++) tick();
    repeat (5) tick();
    chk("busy_start_n11", n11, FILL_EN ? 10 : 0);
    chk("busy_start_nwr", nwr, FILL_EN ? 10 : 0);
    // reset during a fill with a read outstanding
    start_fill(11'h500, 12'd20, 8'h77);
    repeat (4) tick();
    push(1'b0, 11'h123, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nrv = 0; ndone = 0; nwr = 0;
    repeat (30) tick();
    chk("rst_nrv", nrv, 0);
    chk("rst_ndone", ndone, 0);
    chk("rst_nwr", nwr, 0);
    // randomized mixed traffic
    for (int i = 0; i < 800; i++) begin
      if (cq.size() < 2 && $urandom_range(2) != 0) begin
        t.we = 1'($urandom_range(1));
        t.addr = 11'(32'h0F0 + $urandom_range(63));
        t.data = 8'($urandom);
        cq.push_back(t);
      end
      if ($urandom_range(39) == 0) start_fill(11'(32'h0F0 + $urandom_range(63)), 12'($urandom_range(23)), 8'($urandom));
      reset = $urandom_range(299) == 0;
      tick();
    end
    reset = 1'b0;
    cq.delete();
    repeat (40) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
